// File: rtl/beam_thresh_sequencer.sv
// beam_thresh_sequencer
// Holds a shadow threshold per beam and, on commit, streams every shadow entry
// to the trigger core with one-hot write strobes, followed by a single
// apply-all pulse. A full pass runs automatically after reset so the trigger
// core never operates with zero thresholds.
module beam_thresh_sequencer #(
    parameter int          NBEAMS         = 8,
    parameter logic [17:0] DEFAULT_THRESH = 18'd9000,
    localparam int         AW             = $clog2(NBEAMS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [17:0]       wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [17:0]       rd_data_o,
    input  logic              commit_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_wr_o,
    output logic              thresh_update_o
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_UPDATE,
        ST_DONE
    } state_e;

    localparam logic [AW:0]       NBEAMS_W = NBEAMS[AW:0];
    localparam logic [AW-1:0]     LAST_IDX = AW'(NBEAMS - 1);
    localparam logic [NBEAMS-1:0] ONE_HOT0 = {{(NBEAMS-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [17:0]         thresh_q, thresh_d;
    logic [NBEAMS-1:0]   threshWr_q, threshWr_d;
    logic                update_q, update_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [17:0]         rdData_q, rdData_d;
    logic [17:0]         shadow_q [NBEAMS];

    logic                wrAccept;
    logic                rdValid;
    logic                startPass;

    // Out-of-range beam indices are dropped entirely: no write and no re-pass.
    assign wrAccept = wr_en_i && ({1'b0, wr_addr_i} < NBEAMS_W);
    assign rdValid  = ({1'b0, rd_addr_i} < NBEAMS_W);
    assign rdData_d = rdValid ? shadow_q[rd_addr_i] : '0;

    // Shadow threshold storage; writes land at the clock edge, so a pass that samples the same edge sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NBEAMS; i++) begin
                shadow_q[i] <= DEFAULT_THRESH;
            end
        end else if (wrAccept) begin
            shadow_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Sequencer next-state and registered-output values; pending collapses any number of mid-pass requests into one extra pass.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        thresh_d   = thresh_q;
        threshWr_d = '0;
        update_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        startPass  = 1'b0;

        case (state_q)
            ST_INIT: begin
                startPass = 1'b1;
            end
            ST_IDLE: begin
                if (commit_i || pending_q) begin
                    startPass = 1'b1;
                end
            end
            ST_LOAD: begin
                if (wrAccept || commit_i) begin
                    pending_d = 1'b1;
                end
                busy_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_UPDATE;
                    update_d = 1'b1;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    threshWr_d = ONE_HOT0 << idx_d;
                    thresh_d   = shadow_q[idx_d];
                end
            end
            ST_UPDATE: begin
                if (wrAccept || commit_i) begin
                    pending_d = 1'b1;
                end
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                pending_d = wrAccept;
                if (pending_q || commit_i) begin
                    startPass = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (startPass) begin
            state_d    = ST_LOAD;
            idx_d      = '0;
            threshWr_d = ONE_HOT0;
            thresh_d   = shadow_q[0];
            busy_d     = 1'b1;
            pending_d  = (state_q == ST_DONE) && wrAccept;
        end
    end

    // State and output registers; reset drops every output to zero at once, so no update pulse escapes a cut pass.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            thresh_q   <= '0;
            threshWr_q <= '0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdData_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            thresh_q   <= thresh_d;
            threshWr_q <= threshWr_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdData_q   <= rdData_d;
        end
    end

    assign rd_data_o       = rdData_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = threshWr_q;
    assign thresh_update_o = update_q;

endmodule

// File: tb/tb_beam_thresh_sequencer.sv
// tb_beam_thresh_sequencer
// Self-checking bench: table-driven vectors, hand-written corner sequences,
// randomized traffic against a pass-position reference model, and a second
// instance with six beams for the out-of-range address case.
module tb_beam_thresh_sequencer;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [17:0] wrData;
    logic [2:0]  rdAddr;
    logic        commit;
    logic [17:0] rdData;
    logic        busy;
    logic        done;
    logic [17:0] thresh;
    logic [7:0]  threshWr;
    logic        threshUpd;

    logic        rst6_n;
    logic        wr6En;
    logic [2:0]  wr6Addr;
    logic [17:0] wr6Data;
    logic [2:0]  rd6Addr;
    logic        commit6;
    logic [17:0] rd6Data;
    logic        busy6;
    logic        done6;
    logic [17:0] thresh6;
    logic [5:0]  threshWr6;
    logic        threshUpd6;

    int checkCount = 0;
    int errorCount = 0;
    int doneSeen   = 0;
    int updSeen    = 0;

    // Reference model: pos = -2 after reset, -1 idle, 0..N-1 beam issue, N update, N+1 done.
    int          pos;
    bit          pend;
    logic [17:0] mShadow [N];
    logic [7:0]  expWr;
    logic [17:0] expThresh;
    logic        expUpd;
    logic        expDone;
    logic        expBusy;
    logic [17:0] expRd;

    typedef struct {
        logic        wrEn;
        logic [2:0]  wrAddr;
        logic [17:0] wrData;
        logic        commit;
        logic [2:0]  rdAddr;
        logic [7:0]  expWr;
        logic [17:0] expThresh;
        logic        expUpd;
        logic        expDone;
        logic        expBusy;
        logic [17:0] expRd;
    } vec_t;

    vec_t vecs[$];

    beam_thresh_sequencer #(.NBEAMS(8), .DEFAULT_THRESH(18'd9000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
        .rd_addr_i(rdAddr), .rd_data_o(rdData),
        .commit_i(commit), .busy_o(busy), .done_o(done),
        .thresh_o(thresh), .thresh_wr_o(threshWr), .thresh_update_o(threshUpd)
    );

    beam_thresh_sequencer #(.NBEAMS(6), .DEFAULT_THRESH(18'd9000)) dut6 (
        .clk_i(clk), .rst_ni(rst6_n),
        .wr_en_i(wr6En), .wr_addr_i(wr6Addr), .wr_data_i(wr6Data),
        .rd_addr_i(rd6Addr), .rd_data_o(rd6Data),
        .commit_i(commit6), .busy_o(busy6), .done_o(done6),
        .thresh_o(thresh6), .thresh_wr_o(threshWr6), .thresh_update_o(threshUpd6)
    );

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        pos       = -2;
        pend      = 1'b0;
        expWr     = '0;
        expThresh = '0;
        expUpd    = 1'b0;
        expDone   = 1'b0;
        expBusy   = 1'b0;
        expRd     = '0;
        for (int i = 0; i < N; i++) mShadow[i] = 18'd9000;
    endtask

    task automatic modelStep();
        bit wrOk;
        bit start;
        int p;
        if (!rst_n) return;
        wrOk  = wrEn && (int'(wrAddr) < N);
        expRd = mShadow[rdAddr];
        p     = pos;
        start = 1'b0;
        if (p == -2) begin
            start = 1'b1;
            pend  = 1'b0;
        end else if (p == -1) begin
            if (commit || pend) begin
                start = 1'b1;
                pend  = 1'b0;
            end
        end else if (p <= N) begin
            if (wrOk || commit) pend = 1'b1;
            p++;
        end else begin
            if (pend || commit) begin
                start = 1'b1;
                pend  = wrOk;
            end else begin
                p    = -1;
                pend = wrOk;
            end
        end
        if (start) p = 0;
        pos     = p;
        expWr   = (p >= 0 && p < N) ? (8'(1) << p) : 8'h00;
        if (p >= 0 && p < N) expThresh = mShadow[p];
        expUpd  = (p == N);
        expDone = (p == N + 1);
        expBusy = (p >= 0 && p <= N);
        if (wrOk) mShadow[wrAddr] = wrData;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [17:0] wd,
                                 input logic cm, input logic [2:0] ra);
        wrEn   = we;
        wrAddr = wa;
        wrData = wd;
        commit = cm;
        rdAddr = ra;
    endtask

    task automatic checkOutput();
        checkVal("model_wr",     32'(threshWr),  32'(expWr));
        checkVal("model_thresh", 32'(thresh),    32'(expThresh));
        checkVal("model_update", 32'(threshUpd), 32'(expUpd));
        checkVal("model_done",   32'(done),      32'(expDone));
        checkVal("model_busy",   32'(busy),      32'(expBusy));
        checkVal("model_rd",     32'(rdData),    32'(expRd));
        if (threshWr != 8'h00 && threshUpd) begin
            checkVal("wr_update_overlap", 32'(1), 32'(0));
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        doneSeen += int'(done);
        updSeen  += int'(threshUpd);
    endtask

    function automatic vec_t mkVec(input logic we, input logic [2:0] wa, input logic [17:0] wd,
                                   input logic cm, input logic [2:0] ra, input logic [7:0] ew,
                                   input logic [17:0] et, input logic eu, input logic ed,
                                   input logic eb, input logic [17:0] er);
        vec_t v;
        v.wrEn = we; v.wrAddr = wa; v.wrData = wd; v.commit = cm; v.rdAddr = ra;
        v.expWr = ew; v.expThresh = et; v.expUpd = eu; v.expDone = ed; v.expBusy = eb; v.expRd = er;
        return v;
    endfunction

    initial begin
        logic [17:0] rec;
        bit          found;
        logic        anyBusy;

        clk = 0;
        rst_n = 0;
        rst6_n = 0;
        applyStimulus(0, 0, 0, 0, 0);
        wr6En = 0; wr6Addr = 0; wr6Data = 0; rd6Addr = 0; commit6 = 0;
        modelReset();

        // Power-up pass: one-hot walk at default threshold, then update and done.
        for (int i = 0; i < N; i++)
            vecs.push_back(mkVec(0, 0, 0, 0, 0, 8'(1) << i, 18'd9000, 0, 0, 1, 18'd9000));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 8'h00, 18'd9000, 1, 0, 1, 18'd9000));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 8'h00, 18'd9000, 0, 1, 0, 18'd9000));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 8'h00, 18'd9000, 0, 0, 0, 18'd9000));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 8'h00, 18'd9000, 0, 0, 0, 18'd9000));
        // Write beam3 while idle (read of same address returns old value), then commit.
        vecs.push_back(mkVec(1, 3, 18'd12345, 0, 3, 8'h00, 18'd9000, 0, 0, 0, 18'd9000));
        vecs.push_back(mkVec(0, 0, 0, 1, 3, 8'h01, 18'd9000, 0, 0, 1, 18'd12345));
        for (int i = 1; i < N; i++)
            vecs.push_back(mkVec(0, 0, 0, 0, 3, 8'(1) << i, (i == 3) ? 18'd12345 : 18'd9000,
                                 0, 0, 1, 18'd12345));
        vecs.push_back(mkVec(0, 0, 0, 0, 3, 8'h00, 18'd9000, 1, 0, 1, 18'd12345));
        vecs.push_back(mkVec(0, 0, 0, 0, 3, 8'h00, 18'd9000, 0, 1, 0, 18'd12345));

        #1;
        checkVal("reset_wr",     32'(threshWr),  0);
        checkVal("reset_thresh", 32'(thresh),    0);
        checkVal("reset_update", 32'(threshUpd), 0);
        checkVal("reset_done",   32'(done),      0);
        checkVal("reset_busy",   32'(busy),      0);
        checkVal("reset_rd",     32'(rdData),    0);
        stepCycle();
        stepCycle();
        rst_n = 1;

        $display("[TB] table vectors");
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].wrEn, vecs[k].wrAddr, vecs[k].wrData, vecs[k].commit, vecs[k].rdAddr);
            stepCycle();
            checkVal($sformatf("vec%0d_wr", k),     32'(threshWr),  32'(vecs[k].expWr));
            checkVal($sformatf("vec%0d_thresh", k), 32'(thresh),    32'(vecs[k].expThresh));
            checkVal($sformatf("vec%0d_update", k), 32'(threshUpd), 32'(vecs[k].expUpd));
            checkVal($sformatf("vec%0d_done", k),   32'(done),      32'(vecs[k].expDone));
            checkVal($sformatf("vec%0d_busy", k),   32'(busy),      32'(vecs[k].expBusy));
            checkVal($sformatf("vec%0d_rd", k),     32'(rdData),    32'(vecs[k].expRd));
        end
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) stepCycle();

        $display("[TB] write during issue of beam6 triggers one re-pass");
        doneSeen = 0;
        applyStimulus(0, 0, 0, 1, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (threshWr == 8'h40) found = 1;
            else stepCycle();
        end
        checkVal("t3_reach_beam6", 32'(found), 1);
        applyStimulus(1, 5, 18'd500, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0);
        rec = '0;
        for (int i = 0; i < 25; i++) begin
            stepCycle();
            if (threshWr == 8'h20) rec = thresh;
        end
        checkVal("t3_beam5_value", 32'(rec), 500);
        checkVal("t3_done_pulses", doneSeen, 2);

        $display("[TB] three commits during a pass collapse into one");
        updSeen = 0;
        applyStimulus(0, 0, 0, 1, 0);
        stepCycle();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, (k == 1 || k == 3 || k == 5), 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        repeat (25) stepCycle();
        checkVal("t4_update_pulses", updSeen, 2);

        $display("[TB] reset mid-pass");
        applyStimulus(0, 0, 0, 1, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (threshWr == 8'h10) found = 1;
            else stepCycle();
        end
        checkVal("t5_reach_beam4", 32'(found), 1);
        updSeen = 0;
        rst_n = 0;
        #1;
        checkVal("t5_async_wr",     32'(threshWr),  0);
        checkVal("t5_async_busy",   32'(busy),      0);
        checkVal("t5_async_thresh", 32'(thresh),    0);
        modelReset();
        stepCycle();
        stepCycle();
        checkVal("t5_no_update_in_reset", updSeen, 0);
        rst_n = 1;
        rec = '0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (threshWr == 8'h08) rec = thresh;
        end
        checkVal("t5_beam3_default", 32'(rec), 9000);
        checkVal("t5_update_pulses", updSeen, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) == 0, 3'($urandom % 8), 18'($urandom),
                          ($urandom % 16) == 0, 3'($urandom % 8));
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        repeat (30) stepCycle();

        $display("[TB] six-beam instance");
        rst6_n = 1;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkVal($sformatf("t6_wr%0d", i), 32'(threshWr6), 32'(6'(1) << i));
            checkVal($sformatf("t6_thresh%0d", i), 32'(thresh6), 9000);
        end
        stepCycle();
        checkVal("t6_update", 32'(threshUpd6), 1);
        checkVal("t6_update_wr", 32'(threshWr6), 0);
        stepCycle();
        checkVal("t6_done", 32'(done6), 1);
        stepCycle();
        wr6En = 1; wr6Addr = 7; wr6Data = 18'd1;
        stepCycle();
        wr6En = 0;
        anyBusy = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            anyBusy = anyBusy | busy6 | (threshWr6 != 6'h00);
        end
        checkVal("t6_no_extra_pass", 32'(anyBusy), 0);
        for (int i = 0; i < 6; i++) begin
            rd6Addr = 3'(i);
            stepCycle();
            checkVal($sformatf("t6_shadow%0d", i), 32'(rd6Data), 9000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, checks %0d", checkCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
